// File: rtl/minilab1_pkg.sv
// Shared types and sizing for the systolic-array loader and the MAC/FIFO top.
// The fill controller's optional cycle counter is enabled with FIFO_FILL_PERF_EN.
package minilab1_pkg;

    localparam int FILL_DATA_WIDTH = 8;
    localparam int FILL_WORD_BYTES = 8;
    localparam int FILL_NUM_ROWS   = 9;
    localparam int FILL_ADDR_WIDTH = 32;

    localparam int WORD_WIDTH = FILL_DATA_WIDTH * FILL_WORD_BYTES;
    localparam int ROW_W      = $clog2(FILL_NUM_ROWS);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        UNPACK,
        DONE
    } fill_state_t;

endpackage

// File: rtl/row_unpacker.sv
// Holds one memory word and hands it out LSB byte first, one byte per accepted write.
// The byte index only moves on a real write, so a full FIFO stalls without dropping data.
module row_unpacker
    import minilab1_pkg::*;
#(
    parameter int DATA_WIDTH = FILL_DATA_WIDTH,
    parameter int WORD_BYTES = FILL_WORD_BYTES
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load,
    input  logic [DATA_WIDTH*WORD_BYTES-1:0] word,
    input  logic                             active,
    input  logic                             full,
    output logic [DATA_WIDTH-1:0]            byte_data,
    output logic                             wr_en,
    output logic                             last
);

    localparam int WORD_W = DATA_WIDTH * WORD_BYTES;
    localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  byte_idx;

    // Word storage is pure data; the index below decides what is valid.
    always_ff @(posedge clk) begin
        if (load) begin
            word_q <= word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= '0;
        end else if (load) begin
            byte_idx <= '0;
        end else if (wr_en) begin
            byte_idx <= last ? '0 : byte_idx + IDX_W'(1);
        end
    end

    assign wr_en     = active & ~full;
    assign last      = wr_en && (byte_idx == IDX_W'(WORD_BYTES - 1));
    assign byte_data = word_q[byte_idx*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/fifo_fill_ctrl.sv
// Loads the systolic array's row FIFOs: one memory word per row, unpacked into one byte per cycle.
// Define FIFO_FILL_PERF_EN to add the perf_cycles busy-cycle counter output.
module fifo_fill_ctrl
    import minilab1_pkg::*;
#(
    parameter int DATA_WIDTH = FILL_DATA_WIDTH,
    parameter int WORD_BYTES = FILL_WORD_BYTES,
    parameter int NUM_ROWS   = FILL_NUM_ROWS,
    parameter int ADDR_WIDTH = FILL_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    output logic                             busy,
    output logic                             done,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic                             mem_read,
    input  logic                             mem_waitrequest,
    input  logic [DATA_WIDTH*WORD_BYTES-1:0] mem_readdata,
    input  logic                             mem_readdatavalid,
    output logic [NUM_ROWS-1:0]              fifo_wren,
    output logic [DATA_WIDTH-1:0]            fifo_wdata,
    input  logic [NUM_ROWS-1:0]              fifo_full
`ifdef FIFO_FILL_PERF_EN
    ,
    output logic [31:0]                      perf_cycles
`endif
);

    localparam int ROW_CNT_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    fill_state_t            state, state_nxt;
    logic [ROW_CNT_W-1:0]   row;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic                   start_ok;
    logic                   word_load;
    logic                   unpack_active;
    logic [DATA_WIDTH-1:0]  byte_data;
    logic                   byte_wr;
    logic                   byte_last;

    assign start_ok      = (state == IDLE) && start;
    assign word_load     = (state == WAIT) && mem_readdatavalid;
    assign unpack_active = (state == UNPACK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     if (!mem_waitrequest) state_nxt = WAIT;
            WAIT:    if (mem_readdatavalid) state_nxt = UNPACK;
            UNPACK:  if (byte_last) state_nxt = (row == ROW_CNT_W'(NUM_ROWS - 1)) ? DONE : REQ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
        end else if (start_ok) begin
            row <= '0;
        end else if (byte_last && (row != ROW_CNT_W'(NUM_ROWS - 1))) begin
            row <= row + ROW_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (start_ok) begin
            base_q <= base_addr;
        end
    end

    // Address is gated by state so it reads zero whenever no request is open.
    assign mem_read    = (state == REQ);
    assign mem_address = mem_read ? base_q + ADDR_WIDTH'(row) : '0;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    row_unpacker #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORD_BYTES (WORD_BYTES)
    ) u_row_unpacker (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (word_load),
        .word      (mem_readdata),
        .active    (unpack_active),
        .full      (fifo_full[row]),
        .byte_data (byte_data),
        .wr_en     (byte_wr),
        .last      (byte_last)
    );

    // Write port is registered: the FIFO sees the write one cycle after the full check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wren  <= '0;
            fifo_wdata <= '0;
        end else begin
            fifo_wren <= byte_wr ? (NUM_ROWS'(1) << row) : '0;
            if (byte_wr) begin
                fifo_wdata <= byte_data;
            end
        end
    end

`ifdef FIFO_FILL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
        end else if (start_ok) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Scoreboard bench for fifo_fill_ctrl: directed stall/reset cases plus randomized loads.
// Build with FIFO_FILL_PERF_EN defined to also exercise perf_cycles.
module tb_fifo_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        busy;
    logic        done;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_waitrequest;
    logic [63:0] mem_readdata;
    logic        mem_readdatavalid;
    logic [8:0]  fifo_wren;
    logic [7:0]  fifo_wdata;
    logic [8:0]  fifo_full;
`ifdef FIFO_FILL_PERF_EN
    logic [31:0] perf_cycles;
`endif

    fifo_fill_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .base_addr         (base_addr),
        .busy              (busy),
        .done              (done),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .fifo_wren         (fifo_wren),
        .fifo_wdata        (fifo_wdata),
        .fifo_full         (fifo_full)
`ifdef FIFO_FILL_PERF_EN
        ,
        .perf_cycles       (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] wren;
        logic [7:0] data;
    } wr_t;

    wr_t         exp_wr_q[$];
    logic [31:0] exp_addr_q[$];
    int          exp_lat_q[$];

    int          vectors = 0;
    int          miscompares = 0;
    int          busy_cnt = 0;
    int          wr_cnt_run = 0;

    logic [7:0]  salt = 8'h00;
    logic        rand_en = 1'b0;
    int          wait_cfg = 0;
    int          full_cfg = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: byte k of the word at address a is low8(a*8+k) ^ salt.
    function automatic logic [63:0] word_of(input logic [31:0] a, input logic [7:0] s);
        logic [63:0] w;
        logic [31:0] t;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            t = a * 32'd8 + 32'(k);
            w[k*8 +: 8] = t[7:0] ^ s;
        end
        return w;
    endfunction

    // Reference: rows load in order, FIFO r receives the bytes of mem[base+r] LSB first.
    task automatic do_start(input logic [31:0] base, input logic [7:0] s, input int lat);
        logic [31:0] a;
        logic [31:0] t;
        wr_t         e;
        salt = s;
        for (int r = 0; r < 9; r++) begin
            a = base + 32'(r);
            exp_addr_q.push_back(a);
            for (int k = 0; k < 8; k++) begin
                t = a * 32'd8 + 32'(k);
                e.wren = 9'd1 << r;
                e.data = t[7:0] ^ s;
                exp_wr_q.push_back(e);
            end
        end
        exp_lat_q.push_back(lat);
        base_addr = base;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
`ifdef FIFO_FILL_PERF_EN
        check("perf_cleared_on_start", 64'(perf_cycles), 64'd0);
`endif
    endtask

    task automatic flush_model();
        exp_wr_q.delete();
        exp_addr_q.delete();
        exp_lat_q.delete();
    endtask

    // Returns in the DONE cycle, one time unit after its rising edge.
    task automatic wait_done(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no done within %0d cycles", limit);
            rst_n = 1'b0;
            flush_model();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
    endtask

    task automatic settle_idle();
        @(posedge clk);
        #1;
`ifdef FIFO_FILL_PERF_EN
        check("perf_after_done", 64'(perf_cycles), 64'(busy_total_exp));
`endif
        repeat (2) @(posedge clk);
        #1;
        check("busy_low_after_done", 64'(busy), 64'd0);
`ifdef FIFO_FILL_PERF_EN
        check("perf_frozen", 64'(perf_cycles), 64'(busy_total_exp));
`endif
    endtask

    int busy_total_exp = 91;

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_mem_read"}, 64'(mem_read), 64'd0);
        check({tag, "_mem_address"}, 64'(mem_address), 64'd0);
        check({tag, "_fifo_wren"}, 64'(fifo_wren), 64'd0);
        check({tag, "_fifo_wdata"}, 64'(fifo_wdata), 64'd0);
`ifdef FIFO_FILL_PERF_EN
        check({tag, "_perf"}, 64'(perf_cycles), 64'd0);
`endif
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read, a write or done.
    initial begin
        wr_t e;
        int  lat;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt   = 0;
                wr_cnt_run = 0;
            end else begin
                if (busy) busy_cnt++;
                if (mem_read) begin
                    if (exp_addr_q.size() == 0) begin
                        check("unexpected_mem_read", 64'(mem_address), 64'hDEAD);
                    end else begin
                        check("mem_address", 64'(mem_address), 64'(exp_addr_q[0]));
                        if (!mem_waitrequest) void'(exp_addr_q.pop_front());
                    end
                end
                if (fifo_wren != '0) begin
                    wr_cnt_run++;
                    if (exp_wr_q.size() == 0) begin
                        check("unexpected_write", 64'(fifo_wren), 64'd0);
                    end else begin
                        e = exp_wr_q.pop_front();
                        check("fifo_wren", 64'(fifo_wren), 64'(e.wren));
                        check("fifo_wdata", 64'(fifo_wdata), 64'(e.data));
                    end
                end
                if (done) begin
                    if (exp_lat_q.size() == 0) begin
                        check("unexpected_done", 64'(done), 64'd0);
                    end else begin
                        lat = exp_lat_q.pop_front();
                        if (lat > 0) check("done_latency", 64'(busy_cnt), 64'(lat));
                    end
                    check("writes_per_load", 64'(wr_cnt_run), 64'd72);
                    check("model_drained", 64'(exp_wr_q.size() + exp_addr_q.size()), 64'd0);
                    busy_cnt   = 0;
                    wr_cnt_run = 0;
                end
            end
        end
    end

    // Memory and FIFO-full driver; reacts to the DUT's requests and writes.
    initial begin
        int          reads;
        int          r2wr;
        int          wleft;
        int          fleft;
        logic        acc;
        logic [31:0] a;
        reads = 0; r2wr = 0; wleft = 0; fleft = 0;
        mem_waitrequest   = 1'b0;
        mem_readdatavalid = 1'b0;
        mem_readdata      = '0;
        fifo_full         = '0;
        forever begin
            @(negedge clk);
            acc = rst_n && mem_read && !mem_waitrequest;
            a   = mem_address;
            if (start && !busy) begin
                reads = 0;
                r2wr  = 0;
                wleft = wait_cfg;
                fleft = 0;
            end
            if (acc) reads++;
            if (fifo_wren[2]) begin
                r2wr++;
                if (r2wr == 4) fleft = full_cfg;
            end
            @(posedge clk);
            #1;
            mem_readdatavalid = acc || ($urandom_range(0, 3) == 0);
            mem_readdata      = acc ? word_of(a, salt) : {$urandom, $urandom};
            if (mem_read && reads == 4 && wleft > 0) begin
                mem_waitrequest = 1'b1;
                wleft--;
            end else begin
                mem_waitrequest = rand_en ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
            fifo_full = rand_en ? 9'($urandom & $urandom) : 9'd0;
            if (fleft > 0) begin
                fifo_full[2] = 1'b1;
                fleft--;
            end
        end
    end

    initial begin
        bit found;
        rst_n     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Zero-wait baseline.
        busy_total_exp = 91;
        do_start(32'h100, 8'h00, 91);
        wait_done(400, found);
        settle_idle();

        // Waitrequest held three cycles on row 4.
        wait_cfg = 3;
        busy_total_exp = 94;
        do_start(32'h100, 8'h5A, 94);
        wait_done(400, found);
        settle_idle();
        wait_cfg = 0;

        // FIFO 2 full for five cycles after its byte 3 is written.
        full_cfg = 5;
        busy_total_exp = 96;
        do_start(32'h100, 8'hC3, 96);
        wait_done(400, found);
        settle_idle();
        full_cfg = 0;

        // Extra start in UNPACK of row 6, then start raised in the DONE cycle.
        busy_total_exp = 91;
        do_start(32'h4000, 8'h11, 91);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (mem_read && mem_address == 32'h4006) break;
        end
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(400, found);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("start_in_done_ignored", 64'(busy), 64'd0);
            @(posedge clk);
            #1;
        end

        // Reset in the middle of row 5, then reload with a new base.
        do_start(32'h2000, 8'h77, 91);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (fifo_wren[5]) break;
        end
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midload_reset");
        flush_model();
        @(posedge clk);
        #1 rst_n = 1'b1;
        busy_total_exp = 91;
        do_start(32'h3000, 8'h3C, 91);
        wait_done(400, found);
        settle_idle();

        // Randomized stalls, spurious readdatavalid, address wrap.
        rand_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] b;
            b = (i == 0) ? 32'hFFFF_FFFC : $urandom;
            do_start(b, 8'($urandom), -1);
            wait_done(3000, found);
            repeat (3) @(posedge clk);
            #1;
            check("rand_busy_low", 64'(busy), 64'd0);
        end
        rand_en = 1'b0;

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
